light_source_switch: RTL
========================

# light_source_switch

Parametrised N-channel light-pattern source selector with an Avalon-MM slave register interface. It routes one of NUM_CH pattern generator outputs to the LED driver path. Selection is manual (software-written) or automatic (round-robin with a programmable dwell time). Every source change inserts a fixed dark gap so that partial frames from two sources never mix on the LEDs.

## Interface
Parameters:
- WIDTH, 3, bits per channel (one light output word)
- NUM_CH, 4, number of input channels, 2..16
- SEL_W, 2, channel index width; NUM_CH ≤ 2^SEL_W
- DWELL_W, 32, dwell counter width
- BLANK_CYCLES, 2, output-zero cycles inserted per source change, ≥ 0

Ports:
- clk  in  1  system clock; one clock, all logic on the rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register index
- write  in  1  write strobe, sampled on clk
- writedata  in  32  write data
- read  in  1  read strobe
- readdata  out  32  read data, registered
- in_data  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out  out  WIDTH  selected channel, registered
- blanking  out  1  high while in BLANK state

## Operation
Registers:
- 0 CTRL (R/W): bit0 MODE (0 manual, 1 auto), bit1 EN (0 forces out = 0).
- 1 SEL (R/W): manual target sel_reg = writedata[SEL_W-1:0]. A write with index ≥ NUM_CH is ignored; sel_reg is unchanged.
- 2 DWELL (R/W): dwell period in cycles. A value of 0 behaves as 1.
- 3 STATUS (RO): bits[SEL_W-1:0] active channel, bit8 blanking. Writes to STATUS are ignored.

Reset values:
- MODE=0, EN=1, sel_reg=0, DWELL=0, active=0, target=0.
- State HOLD; dwell_cnt=0, blank_cnt=0.
- out=0, readdata=0, blanking=0.

State machine, two states:
- HOLD
  - Manual mode: if sel_reg ≠ active, a switch request is raised with target = sel_reg.
  - Auto mode: dwell_cnt increments each cycle. When dwell_cnt = max(DWELL,1)−1, a request is raised with target = active+1, wrapping from NUM_CH−1 to 0, and dwell_cnt returns to 0.
  - On a request with BLANK_CYCLES > 0: move to BLANK, blank_cnt=0.
  - On a request with BLANK_CYCLES = 0: active ← target in the same edge; state remains HOLD.
- BLANK
  - blank_cnt increments each cycle.
  - At blank_cnt = BLANK_CYCLES−1: active ← target, dwell_cnt ← 0, state → HOLD.
  - target is frozen for the whole gap. If sel_reg changes during BLANK, the new switch is processed after the return to HOLD.

Other rules:
- Writing CTRL.MODE clears dwell_cnt.
- Switching auto→manual with sel_reg ≠ active raises a manual request on the next HOLD cycle.
- out ← (next state HOLD and EN) ? in_data[next active] : 0, updated every edge.
- EN=0 does not stop the state machine or the dwell counter.
- Simultaneous write to SEL and a dwell expiry in auto mode: the auto request wins; sel_reg still updates.
- A read in the same cycle as a write to the same register returns the pre-write value.
- Asserting reset_n low mid-gap or mid-dwell returns all state and outputs to reset values immediately, asynchronously.

## Timing
- HOLD pass-through latency: out at edge n+1 reflects in_data sampled at edge n (1 cycle).
- Manual switch, with SEL write sampled at edge E0:
  - out = 0 after E0 … E(B−1), where B = BLANK_CYCLES.
  - New channel appears on out after edge E_B; blanking is high over the same interval.
  - With B = 0, the new channel appears after E0 with no gap.
- Auto mode: each channel is shown for max(DWELL,1) cycles, followed by B zero cycles.
- Register writes take effect at the sampling edge.
- readdata is valid the cycle after read is asserted; readdata holds its value when read is low.

## Test plan
- Reset: assert reset_n=0 mid-operation -> out=0, readdata=0, blanking=0 asynchronously; after release, out tracks channel 0 with 1-cycle latency.
- Manual switch: B=2, in_data ch0=3'b001, ch2=3'b100; write SEL=2 at E0 -> out=0 for exactly 2 cycles, then 3'b100; STATUS read returns 0x002.
- No-op and range checks: write SEL=0 while active=0 -> no blank, out unchanged; write SEL=5 with NUM_CH=4 -> ignored, SEL reads back the previous value.
- Auto cycle: DWELL=3, MODE=1, B=2 -> out sequence ch0×3, 0×2, ch1×3, 0×2, ch2×3, 0×2, ch3×3, 0×2, ch0 (wrap); DWELL=0 behaves as DWELL=1.
- Write during blank: write SEL=1 in BLANK toward ch3 -> ch3 is shown for 1 cycle, then a second 2-cycle gap, then ch1.
- Enable: CTRL.EN=0 -> out=0 on the next edge while STATUS.active continues advancing in auto mode; EN=1 -> current active channel reappears after 1 cycle.

Source files
------------

// File: rtl/light_source_switch.sv
// N-channel light-pattern source selector with manual/auto round-robin selection,
// a dark gap on every source change, and an Avalon-MM register slave.
module light_source_switch #(
  parameter int WIDTH        = 3,
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = 2,
  parameter int DWELL_W      = 32,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              address,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic                    read,
  output logic [31:0]             readdata,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]        out,
  output logic                    blanking
);

  localparam logic [0:0] HOLD  = 1'b0;
  localparam logic [0:0] BLANK = 1'b1;

  localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BCW-1:0]   BLAST   = BCW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [NUM_CH-1:0][WIDTH-1:0] ch;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch[k] = in_data[k*WIDTH +: WIDTH];
  end

  logic [0:0]         state, state_n;
  logic               mode, en;
  logic [SEL_W-1:0]   sel_reg, active, active_n, target, target_n;
  logic [DWELL_W-1:0] dwell, dwell_cnt, dwell_cnt_n, dwell_last;
  logic [BCW-1:0]     blank_cnt, blank_cnt_n;

  logic               wr_ctrl, wr_sel, wr_dwell, en_eff, req;
  logic [SEL_W-1:0]   sel_eff, req_tgt;
  logic [WIDTH-1:0]   out_n;
  logic [31:0]        rd_val;

  assign blanking = (state == BLANK);

  always_comb begin
    wr_ctrl    = write && (address == 2'd0);
    wr_sel     = write && (address == 2'd1) && (writedata < 32'(NUM_CH));
    wr_dwell   = write && (address == 2'd2);
    // A SEL write is visible to the FSM on its own sampling edge; MODE is not,
    // so an auto->manual change acts on the following HOLD cycle.
    en_eff     = wr_ctrl ? writedata[1] : en;
    sel_eff    = wr_sel ? writedata[SEL_W-1:0] : sel_reg;
    dwell_last = (dwell == '0) ? '0 : dwell - 1'b1;

    state_n     = state;
    active_n    = active;
    target_n    = target;
    dwell_cnt_n = dwell_cnt;
    blank_cnt_n = blank_cnt;
    req         = 1'b0;
    req_tgt     = target;

    case (state)
      HOLD: begin
        if (mode) begin
          // >= so a DWELL shrunk below the running count still expires
          if (dwell_cnt >= dwell_last) begin
            req         = 1'b1;
            req_tgt     = (active == LAST_CH) ? '0 : active + 1'b1;
            dwell_cnt_n = '0;
          end else begin
            dwell_cnt_n = dwell_cnt + 1'b1;
          end
        end else if (sel_eff != active) begin
          req     = 1'b1;
          req_tgt = sel_eff;
        end
        if (req) begin
          target_n = req_tgt;
          if (BLANK_CYCLES == 0) begin
            active_n = req_tgt;
          end else begin
            state_n     = BLANK;
            blank_cnt_n = '0;
          end
        end
      end
      default: begin
        if (blank_cnt == BLAST) begin
          active_n    = target;
          dwell_cnt_n = '0;
          state_n     = HOLD;
        end else begin
          blank_cnt_n = blank_cnt + 1'b1;
        end
      end
    endcase

    if (wr_ctrl) dwell_cnt_n = '0;

    out_n = (state_n == HOLD && en_eff) ? ch[active_n] : '0;

    rd_val = '0;
    case (address)
      2'd0: rd_val[1:0] = {en, mode};
      2'd1: rd_val[SEL_W-1:0] = sel_reg;
      2'd2: rd_val = 32'(dwell);
      default: begin
        rd_val[SEL_W-1:0] = active;
        rd_val[8]         = (state == BLANK);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HOLD;
      mode      <= 1'b0;
      en        <= 1'b1;
      sel_reg   <= '0;
      dwell     <= '0;
      active    <= '0;
      target    <= '0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      out       <= '0;
      readdata  <= '0;
    end else begin
      state     <= state_n;
      active    <= active_n;
      target    <= target_n;
      dwell_cnt <= dwell_cnt_n;
      blank_cnt <= blank_cnt_n;
      out       <= out_n;
      if (wr_ctrl) begin
        mode <= writedata[0];
        en   <= writedata[1];
      end
      if (wr_sel)   sel_reg <= writedata[SEL_W-1:0];
      if (wr_dwell) dwell   <= writedata[DWELL_W-1:0];
      if (read)     readdata <= rd_val;
    end
  end

endmodule
